// File: rtl/motoro3_ramp_ctrl.sv
// motoro3_ramp_ctrl: soft-start / soft-stop sequencer for the three-phase driver.
// Turns a run/stop level and a target frequency into the bridge enable and a
// frequency set-point that moves in saturating steps once per ramp tick.
// Emergency stop forces the bridge off and latches a fault until the
// command source has also dropped its run request.
module motoro3_ramp_ctrl #(
   parameter int FREQ_W   = 16,
   parameter int STEP_W   = 8,
   parameter int TICK_DIV = 10000,
   parameter int FREQ_MIN = 10
) (
   input  logic              clk,
   input  logic              nRst,
   input  logic              cmdRun,
   input  logic [FREQ_W-1:0] cmdTarget,
   input  logic [STEP_W-1:0] rampStep,
   input  logic              estop,
   output logic              m3start,
   output logic [FREQ_W-1:0] m3freq,
   output logic              busy,
   output logic              atSpeed,
   output logic              fault
);

   localparam int                CNT_W    = $clog2(TICK_DIV);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TICK_DIV - 1);
   localparam logic [FREQ_W-1:0] F_MIN    = FREQ_W'(FREQ_MIN);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_RAMPUP = 3'd2,
      ST_RUN    = 3'd3,
      ST_RAMPDN = 3'd4,
      ST_FAULT  = 3'd5
   } state_t;

   // Add at FREQ_W+1 bits and clamp to full scale instead of wrapping.
   function automatic logic [FREQ_W-1:0] sat_add(input logic [FREQ_W-1:0] a,
                                                 input logic [FREQ_W:0]   b);
      logic [FREQ_W:0] w;
      w = {1'b0, a} + b;
      return w[FREQ_W] ? {FREQ_W{1'b1}} : w[FREQ_W-1:0];
   endfunction

   // Subtract at FREQ_W+1 bits and clamp to zero on borrow.
   function automatic logic [FREQ_W-1:0] sat_sub(input logic [FREQ_W-1:0] a,
                                                 input logic [FREQ_W:0]   b);
      logic [FREQ_W:0] w;
      w = {1'b0, a} - b;
      return w[FREQ_W] ? {FREQ_W{1'b0}} : w[FREQ_W-1:0];
   endfunction

   state_t              state_r, state_nxt_s;
   logic [FREQ_W-1:0]   freq_r, freq_nxt_s;
   logic [FREQ_W-1:0]   goal_r, goal_nxt_s;
   logic [CNT_W-1:0]    cnt_r;
   logic                cnt_clr_s;
   logic                tick_s;
   logic [FREQ_W:0]     step_s;
   logic [FREQ_W-1:0]   tgt_s;
   logic [FREQ_W-1:0]   up_val_s, dn_val_s;
   logic                up_land_s, dn_land_s;
   logic                stop_s;
   logic                start_nxt_s, busy_nxt_s, at_speed_nxt_s, fault_nxt_s;

   // A zero step would stall the ramp, so it is promoted to one.
   assign step_s    = (rampStep == {STEP_W{1'b0}}) ? {{FREQ_W{1'b0}}, 1'b1}
                                                   : (FREQ_W+1)'(rampStep);
   assign tgt_s     = (cmdTarget < F_MIN) ? F_MIN : cmdTarget;
   assign tick_s    = (cnt_r == CNT_LAST);
   assign up_val_s  = sat_add(freq_r, step_s);
   assign dn_val_s  = sat_sub(freq_r, step_s);
   assign up_land_s = (up_val_s >= goal_r);
   assign dn_land_s = (dn_val_s <= goal_r);
   // Ramp-down is a full stop (not a retarget) when running is no longer requested.
   assign stop_s    = !cmdRun && (goal_r == F_MIN);
   assign m3freq    = freq_r;

   // Ramp tick divider: free-running, restarted whenever START, RAMPDN or FAULT is entered.
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (cnt_clr_s || tick_s) begin
         cnt_r <= {CNT_W{1'b0}};
      end else begin
         cnt_r <= cnt_r + CNT_W'(1);
      end
   end

   // State, set-point, goal and output registers.
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state_r <= ST_IDLE;
         freq_r  <= {FREQ_W{1'b0}};
         goal_r  <= {FREQ_W{1'b0}};
         m3start <= 1'b0;
         busy    <= 1'b0;
         atSpeed <= 1'b0;
         fault   <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         freq_r  <= freq_nxt_s;
         goal_r  <= goal_nxt_s;
         m3start <= start_nxt_s;
         busy    <= busy_nxt_s;
         atSpeed <= at_speed_nxt_s;
         fault   <= fault_nxt_s;
      end
   end

   // Next state and datapath; emergency stop overrides every other transition.
   always_comb begin
      state_nxt_s = state_r;
      freq_nxt_s  = freq_r;
      goal_nxt_s  = goal_r;
      if (estop) begin
         state_nxt_s = ST_FAULT;
         freq_nxt_s  = {FREQ_W{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (cmdRun && (cmdTarget >= F_MIN)) begin
                  state_nxt_s = ST_START;
                  freq_nxt_s  = F_MIN;
                  goal_nxt_s  = tgt_s;
               end else begin
                  freq_nxt_s  = {FREQ_W{1'b0}};
               end
            end
            ST_START: begin
               if (goal_r == F_MIN) begin
                  state_nxt_s = ST_RUN;
               end else begin
                  state_nxt_s = ST_RAMPUP;
               end
            end
            ST_RAMPUP: begin
               if (!tick_s) begin
                  state_nxt_s = ST_RAMPUP;
               end else if (!cmdRun) begin
                  goal_nxt_s  = F_MIN;
                  state_nxt_s = ST_RAMPDN;
               end else if (up_land_s) begin
                  freq_nxt_s  = goal_r;
                  state_nxt_s = ST_RUN;
               end else begin
                  freq_nxt_s  = up_val_s;
               end
            end
            ST_RUN: begin
               if (!tick_s) begin
                  state_nxt_s = ST_RUN;
               end else if (!cmdRun) begin
                  goal_nxt_s  = F_MIN;
                  state_nxt_s = ST_RAMPDN;
               end else if (tgt_s > freq_r) begin
                  goal_nxt_s  = tgt_s;
                  state_nxt_s = ST_RAMPUP;
               end else if (tgt_s < freq_r) begin
                  goal_nxt_s  = tgt_s;
                  state_nxt_s = ST_RAMPDN;
               end else begin
                  state_nxt_s = ST_RUN;
               end
            end
            ST_RAMPDN: begin
               // A stop first lands on FREQ_MIN and switches off on the following tick.
               if (!tick_s) begin
                  state_nxt_s = ST_RAMPDN;
               end else if (!dn_land_s) begin
                  freq_nxt_s  = dn_val_s;
               end else if (stop_s && (freq_r == goal_r)) begin
                  freq_nxt_s  = {FREQ_W{1'b0}};
                  state_nxt_s = ST_IDLE;
               end else if (stop_s) begin
                  freq_nxt_s  = goal_r;
                  state_nxt_s = ST_RAMPDN;
               end else begin
                  freq_nxt_s  = goal_r;
                  state_nxt_s = ST_RUN;
               end
            end
            ST_FAULT: begin
               freq_nxt_s = {FREQ_W{1'b0}};
               if (!cmdRun) begin
                  state_nxt_s = ST_IDLE;
               end else begin
                  state_nxt_s = ST_FAULT;
               end
            end
            default: begin
               state_nxt_s = ST_IDLE;
               freq_nxt_s  = {FREQ_W{1'b0}};
               goal_nxt_s  = {FREQ_W{1'b0}};
            end
         endcase
      end
   end

   // Tick divider restarts on entry into the states that begin a timed phase.
   assign cnt_clr_s = (state_nxt_s != state_r) &&
                      ((state_nxt_s == ST_START) || (state_nxt_s == ST_RAMPDN) ||
                       (state_nxt_s == ST_FAULT));

   // Status outputs decoded from the upcoming state, then registered.
   always_comb begin
      start_nxt_s    = 1'b0;
      busy_nxt_s     = 1'b1;
      at_speed_nxt_s = 1'b0;
      fault_nxt_s    = 1'b0;
      case (state_nxt_s)
         ST_IDLE:   busy_nxt_s     = 1'b0;
         ST_START:  start_nxt_s    = 1'b1;
         ST_RAMPUP: start_nxt_s    = 1'b1;
         ST_RUN: begin
            start_nxt_s    = 1'b1;
            at_speed_nxt_s = 1'b1;
         end
         ST_RAMPDN: start_nxt_s    = 1'b1;
         ST_FAULT:  fault_nxt_s    = 1'b1;
         default:   busy_nxt_s     = 1'b0;
      endcase
   end

endmodule
